fifo_read_streamer: RTL and testbench

- Read-side consumer for the project FIFO (FIFO_WIDTH=16, FIFO_DEPTH=8 configuration).
- Watches the FIFO empty flag and issues rd_en, then captures data_out one cycle later into a 2-entry skid buffer.
- Presents captured words downstream on a valid/ready stream.
- This is the drain end of the interface that the FIFO bench drives on the write side; it guarantees the FIFO never sees a read while empty.

---
 rtl/fifo_read_streamer_if.sv | 49 ++++
 rtl/fifo_read_streamer.sv | 189 ++++++++++++++++++
 tb/tb_fifo_read_streamer.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_streamer_if.sv
// fifo_read_streamer_if
// ---------------------------------------------------------------------------
// Bundles the two handshakes that fifo_read_streamer sits between:
//   FIFO read port : fifo_empty, fifo_underflow, fifo_dout (from the FIFO),
//                    fifo_rd_en (to the FIFO)
//   Output stream  : m_valid, m_data (to downstream), m_ready (from downstream)
//
// Modports:
//   master : the streamer's view (drives fifo_rd_en, m_valid, m_data)
//   slave  : the environment's view (FIFO plus downstream consumer)
//
// FIFO_WIDTH must match the FIFO_WIDTH of the streamer it connects to.
// ---------------------------------------------------------------------------
interface fifo_read_streamer_if #(
  parameter int FIFO_WIDTH = 16
);

  // FIFO read side
  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic [FIFO_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;

  // Downstream valid/ready stream
  logic                  m_valid;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_underflow,
    input  fifo_dout,
    output fifo_rd_en,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    output fifo_empty,
    output fifo_underflow,
    output fifo_dout,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer
// ---------------------------------------------------------------------------
// Drain end of the project FIFO. Watches the FIFO empty flag, issues
// fifo_rd_en whenever there is room for the returning word, captures
// fifo_dout one cycle later into a 2-entry skid buffer and presents the head
// entry on a valid/ready stream. A read is never issued while the FIFO is
// empty.
//
// Ports:
//   clk            in   single clock, everything on posedge
//   rst            in   synchronous, active-high reset
//   flush          in   level; drops buffered and in-flight words at the
//                       next edge and blocks new reads while high
//   bus            if   fifo_read_streamer_if.master
//                       (fifo_empty, fifo_underflow, fifo_dout -> in,
//                        fifo_rd_en -> out, m_valid/m_data -> out,
//                        m_ready -> in)
//   err_underflow  out  sticky; the FIFO reported underflow on a read this
//                       block issued (cleared only by rst)
//
// Optional build macro FIFO_READ_STREAMER_STATS_EN adds:
//   rd_count       out  32-bit saturating count of captured words
//   stall_count    out  32-bit saturating count of cycles with
//                       m_valid=1 and m_ready=0
//   Both clear on rst only; flush leaves them alone.
//
// Parameters:
//   FIFO_WIDTH  data word width
//   SKID_DEPTH  skid buffer entries; the pointer logic assumes exactly 2
//
// Timing note: fifo_rd_en is combinational from m_ready, fifo_empty and
// flush. Downstream logic must not derive m_ready from fifo_rd_en.
// ---------------------------------------------------------------------------
module fifo_read_streamer #(
  parameter int FIFO_WIDTH = 16,
  parameter int SKID_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  fifo_read_streamer_if.master bus,
  output logic                 err_underflow
`ifdef FIFO_READ_STREAMER_STATS_EN
  ,
  output logic [31:0]          rd_count,
  output logic [31:0]          stall_count
`endif
);

  // Reads may be outstanding only while buffered + in-flight words, after
  // this cycle's pop, stay below the buffer size.
  localparam logic [2:0] CREDIT_LIMIT = 3'(SKID_DEPTH);

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  logic [1:0]            occ;
  logic                  inflight;
  logic                  hd;
  logic [FIFO_WIDTH-1:0] skid_buf [2];

  // ------------------------------------------------------------------------
  // Per-cycle decode
  // ------------------------------------------------------------------------
  logic                  m_valid_int;
  logic                  pop;
  logic                  capture;
  logic                  underflow_hit;
  logic                  rd_en;
  logic                  tail;
  logic [1:0]            occ_after_pop;
  logic [1:0]            occ_next;
  logic [2:0]            credit_used;

  assign m_valid_int = (occ != 2'd0);
  assign pop         = m_valid_int & bus.m_ready;

  // Output side: m_data is a plain mux of buffer registers, so there is no
  // combinational path from fifo_dout to the stream.
  assign bus.m_valid    = m_valid_int;
  assign bus.m_data     = skid_buf[hd];
  assign bus.fifo_rd_en = rd_en;

  // Read-credit check, capture qualification and the slot the returning
  // word lands in. The tail slot is hd+occ (mod 2); that is the same slot as
  // new_head+occ_after_pop, so a pop and a capture in one cycle put the new
  // word directly behind the popped one.
  always_comb begin
    occ_after_pop = occ - {1'b0, pop};
    credit_used   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    rd_en         = 1'b0;
    capture       = 1'b0;
    underflow_hit = 1'b0;
    tail          = hd ^ occ[0];

    if (!rst && !flush && !bus.fifo_empty && (credit_used < CREDIT_LIMIT)) begin
      rd_en = 1'b1;
    end

    if (inflight && !flush) begin
      if (bus.fifo_underflow) begin
        underflow_hit = 1'b1;
      end else begin
        capture = 1'b1;
      end
    end

    occ_next = occ_after_pop + {1'b0, capture};
  end

  // ------------------------------------------------------------------------
  // Occupancy, head pointer and in-flight tracking
  // ------------------------------------------------------------------------

  // Flush empties the buffer and rewinds the head; the in-flight flag simply
  // follows fifo_rd_en, which is already forced low during rst and flush,
  // so a word returning during a flush cycle is never captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= 2'd0;
      hd       <= 1'b0;
      inflight <= 1'b0;
    end else if (flush) begin
      occ      <= 2'd0;
      hd       <= 1'b0;
      inflight <= rd_en;
    end else begin
      occ      <= occ_next;
      hd       <= hd ^ pop;
      inflight <= rd_en;
    end
  end

  // ------------------------------------------------------------------------
  // Skid buffer storage
  // ------------------------------------------------------------------------

  // Only the tail slot is written; the head slot is never touched while it
  // is being presented, which keeps m_data stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        skid_buf[i] <= '0;
      end
    end else if (capture) begin
      skid_buf[tail] <= bus.fifo_dout;
    end
  end

  // ------------------------------------------------------------------------
  // Sticky underflow error
  // ------------------------------------------------------------------------

  // Set when the FIFO flags underflow on a word we asked for; the word is
  // discarded. Flush does not clear it, only rst does.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_underflow <= 1'b0;
    end else if (underflow_hit) begin
      err_underflow <= 1'b1;
    end
  end

`ifdef FIFO_READ_STREAMER_STATS_EN
  // ------------------------------------------------------------------------
  // Statistics counters
  // ------------------------------------------------------------------------
  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  // Captured-word counter, saturating, untouched by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= 32'd0;
    end else if (capture && (rd_count != COUNT_MAX)) begin
      rd_count <= rd_count + 32'd1;
    end
  end

  // Backpressure cycle counter, saturating, untouched by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= 32'd0;
    end else if (m_valid_int && !bus.m_ready && (stall_count != COUNT_MAX)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb_fifo_read_streamer
// ---------------------------------------------------------------------------
// Bench for fifo_read_streamer. A small behavioural FIFO (depth 8) feeds the
// read port; a transaction-level reference model tracks which words must
// reach the stream: every word the FIFO hands out is expected downstream in
// FIFO order unless rst or flush hits its capture cycle or the FIFO flags it
// as an underflow; flush and rst also drop everything still buffered.
// Directed scenarios run first, then a randomized phase.
// Honours FIFO_READ_STREAMER_STATS_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_fifo_read_streamer;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic err_underflow;
`ifdef FIFO_READ_STREAMER_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] stall_count;
`endif

  fifo_read_streamer_if #(.FIFO_WIDTH(W)) bus ();

  fifo_read_streamer #(
    .FIFO_WIDTH(W),
    .SKID_DEPTH(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus),
    .err_underflow(err_underflow)
`ifdef FIFO_READ_STREAMER_STATS_EN
    ,
    .rd_count     (rd_count),
    .stall_count  (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------------------
  // Behavioural FIFO (depth 8, registered flags, data valid after rd_en)
  // ------------------------------------------------------------------------
  logic [W-1:0] fifo_q[$];
  logic         fifo_empty_r     = 1'b1;
  logic         fifo_underflow_r = 1'b0;
  logic [W-1:0] fifo_dout_r      = '0;
  int           reads_issued     = 0;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         inj_uf;

  assign bus.fifo_empty     = fifo_empty_r;
  assign bus.fifo_underflow = fifo_underflow_r;
  assign bus.fifo_dout      = fifo_dout_r;

  // Pops on rd_en (flagging underflow when empty or when injection is
  // requested), then accepts a write if not full.
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      reads_issued <= reads_issued + 1;
      if (fifo_q.size() == 0) begin
        fifo_underflow_r <= 1'b1;
      end else begin
        fifo_dout_r      <= fifo_q.pop_front();
        fifo_underflow_r <= inj_uf;
      end
    end else begin
      fifo_underflow_r <= 1'b0;
    end
    if (wr_en && (fifo_q.size() < 8)) begin
      fifo_q.push_back(wr_data);
    end
    fifo_empty_r <= (fifo_q.size() == 0);
  end

  // ------------------------------------------------------------------------
  // Reference model and bookkeeping
  // ------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] out_log[$];
  int           pop_cycles[$];
  logic         exp_inflight;
  logic         exp_err;
  int           cyc;
  int           compared;
  int           mismatched;
`ifdef FIFO_READ_STREAMER_STATS_EN
  logic [31:0]  exp_rd_count;
  logic [31:0]  exp_stall_count;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock: check the current cycle at the falling edge, advance the
  // model to what the next rising edge must produce, then return just after
  // that edge so the caller can drive new inputs.
  task automatic tick();
    logic model_valid;
    logic popped;
    @(negedge clk);
    model_valid = (exp_q.size() != 0);
    checkOutput("m_valid", 32'(bus.m_valid), 32'(model_valid));
    if (model_valid) begin
      checkOutput("m_data", 32'(bus.m_data), 32'(exp_q[0]));
    end
    checkOutput("rd_en_while_empty", 32'(bus.fifo_rd_en & bus.fifo_empty), 32'd0);
    checkOutput("rd_en_while_rst_flush", 32'(bus.fifo_rd_en & (rst | flush)), 32'd0);
    checkOutput("err_underflow", 32'(err_underflow), 32'(exp_err));
    checkOutput("occupancy_bound", 32'(exp_q.size() <= 2), 32'd1);
`ifdef FIFO_READ_STREAMER_STATS_EN
    checkOutput("rd_count", rd_count, exp_rd_count);
    checkOutput("stall_count", stall_count, exp_stall_count);
`endif

    popped = model_valid && bus.m_ready;
    if (rst) begin
      exp_q.delete();
      exp_err      = 1'b0;
      exp_inflight = 1'b0;
`ifdef FIFO_READ_STREAMER_STATS_EN
      exp_rd_count    = '0;
      exp_stall_count = '0;
`endif
    end else begin
`ifdef FIFO_READ_STREAMER_STATS_EN
      if (model_valid && !bus.m_ready && (exp_stall_count != 32'hFFFF_FFFF)) begin
        exp_stall_count++;
      end
`endif
      if (popped) begin
        out_log.push_back(exp_q.pop_front());
        pop_cycles.push_back(cyc);
      end
      if (flush) begin
        exp_q.delete();
      end else if (exp_inflight) begin
        if (bus.fifo_underflow) begin
          exp_err = 1'b1;
        end else begin
          exp_q.push_back(bus.fifo_dout);
`ifdef FIFO_READ_STREAMER_STATS_EN
          if (exp_rd_count != 32'hFFFF_FFFF) begin
            exp_rd_count++;
          end
`endif
        end
      end
      exp_inflight = bus.fifo_rd_en;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rdy, input logic fl, input logic r,
                               input logic we, input logic [W-1:0] wd,
                               input logic uf);
    bus.m_ready = rdy;
    flush       = fl;
    rst         = r;
    wr_en       = we;
    wr_data     = wd;
    inj_uf      = uf;
    tick();
  endtask

  task automatic runUntilPops(input int n, input int bound, input string tag);
    for (int i = 0; (i < bound) && (out_log.size() < n); i++) begin
      tick();
    end
    checkOutput(tag, 32'(out_log.size()), 32'(n));
  endtask

  // ------------------------------------------------------------------------
  // Directed and random sequence
  // ------------------------------------------------------------------------
  initial begin
    int rb;
    compared     = 0;
    mismatched   = 0;
    cyc          = 0;
    rst          = 1'b1;
    flush        = 1'b0;
    bus.m_ready  = 1'b0;
    wr_en        = 1'b0;
    wr_data      = '0;
    inj_uf       = 1'b0;
    exp_inflight = 1'b0;
    exp_err      = 1'b0;
`ifdef FIFO_READ_STREAMER_STATS_EN
    exp_rd_count    = '0;
    exp_stall_count = '0;
`endif
    @(posedge clk);
    #1;

    // Reset state
    tick();
    tick();
    checkOutput("reset_m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("reset_m_data", 32'(bus.m_data), 32'd0);
    checkOutput("reset_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    checkOutput("reset_err", 32'(err_underflow), 32'd0);

    // Basic drain: preload 1..8 under reset, then release with m_ready=1
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, W'(i + 1), 1'b0);
    end
    wr_en = 1'b0;
    rst   = 1'b0;
    out_log.delete();
    pop_cycles.delete();
    #1;
    checkOutput("drain_first_rd_en", 32'(bus.fifo_rd_en), 32'd1);
    tick();
    checkOutput("drain_valid_edge1", 32'(bus.m_valid), 32'd0);
    tick();
    checkOutput("drain_valid_edge2", 32'(bus.m_valid), 32'd1);
    checkOutput("drain_first_word", 32'(bus.m_data), 32'h0001);
    runUntilPops(8, 30, "drain_count");
    for (int i = 0; i < out_log.size(); i++) begin
      checkOutput("drain_order", 32'(out_log[i]), 32'(i + 1));
    end
    if (pop_cycles.size() >= 8) begin
      checkOutput("drain_back_to_back", 32'(pop_cycles[7] - pop_cycles[0]), 32'd7);
    end
    checkOutput("drain_err", 32'(err_underflow), 32'd0);

    // Backpressure: 5 words arrive while m_ready=0 for 10 cycles
    out_log.delete();
    rb = reads_issued;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, (i < 5), W'(32'hA000 + i), 1'b0);
    end
    checkOutput("bp_reads_during_stall", 32'(reads_issued - rb), 32'd2);
    checkOutput("bp_valid", 32'(bus.m_valid), 32'd1);
    checkOutput("bp_head", 32'(bus.m_data), 32'hA000);
    bus.m_ready = 1'b1;
    runUntilPops(5, 30, "bp_count");
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    checkOutput("bp_no_duplicates", 32'(out_log.size()), 32'd5);
    for (int i = 0; i < out_log.size(); i++) begin
      checkOutput("bp_order", 32'(out_log[i]), 32'hA000 + 32'(i));
    end

    // Alternating ready with an 8-word burst
    out_log.delete();
    for (int i = 0; (i < 80) && (out_log.size() < 8); i++) begin
      applyStimulus(i[0], 1'b0, 1'b0, (i < 8), W'(32'hB000 + i), 1'b0);
    end
    wr_en = 1'b0;
    checkOutput("alt_count", 32'(out_log.size()), 32'd8);
    for (int i = 0; i < out_log.size(); i++) begin
      checkOutput("alt_order", 32'(out_log[i]), 32'hB000 + 32'(i));
    end

    // Flush with a read in flight: load under flush (no reads allowed)
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, W'(32'hC000 + i), 1'b0);
    end
    for (int i = 0; (i < 10) && !(exp_inflight && (exp_q.size() == 1)); i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    end
    checkOutput("flush_setup", 32'(exp_inflight && (exp_q.size() == 1)), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("flush_valid_dropped", 32'(bus.m_valid), 32'd0);
    flush = 1'b0;
    #1;
    checkOutput("flush_resume_rd_en", 32'(bus.fifo_rd_en), 32'd1);
    out_log.delete();
    bus.m_ready = 1'b1;
    runUntilPops(2, 20, "flush_count");
    if (out_log.size() >= 2) begin
      checkOutput("flush_next_word", 32'(out_log[0]), 32'hC002);
      checkOutput("flush_last_word", 32'(out_log[1]), 32'hC003);
    end

    // Injected underflow on the read of 0xD000
    out_log.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'hD000, 1'b0);
    wr_en = 1'b0;
    #1;
    checkOutput("uf_rd_en", 32'(bus.fifo_rd_en), 32'd1);
    inj_uf = 1'b1;
    tick();
    inj_uf = 1'b0;
    tick();
    checkOutput("uf_err_set", 32'(err_underflow), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, (i < 2), W'(32'hD001 + i), 1'b0);
    end
    runUntilPops(2, 20, "uf_count");
    if (out_log.size() >= 2) begin
      checkOutput("uf_word_skipped", 32'(out_log[0]), 32'hD001);
      checkOutput("uf_next_word", 32'(out_log[1]), 32'hD002);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("uf_err_survives_flush", 32'(err_underflow), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    rst = 1'b0;
    checkOutput("uf_err_cleared_by_rst", 32'(err_underflow), 32'd0);

    // Reset mid-stream with a word buffered and one in flight
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, W'(32'hE000 + i), 1'b0);
    end
    for (int i = 0; (i < 10) && !(exp_inflight && (exp_q.size() == 1)); i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    end
    checkOutput("rst_setup", 32'(exp_inflight && (exp_q.size() == 1)), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("rst_m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("rst_m_data", 32'(bus.m_data), 32'd0);
    checkOutput("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
`ifdef FIFO_READ_STREAMER_STATS_EN
    checkOutput("rst_rd_count", rd_count, 32'd0);
`endif
    rst = 1'b0;
    out_log.delete();
    bus.m_ready = 1'b1;
    runUntilPops(2, 20, "rst_count");
    if (out_log.size() >= 2) begin
      checkOutput("rst_next_word", 32'(out_log[0]), 32'hE002);
      checkOutput("rst_last_word", 32'(out_log[1]), 32'hE003);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 149) == 0), ($urandom_range(0, 2) != 0),
                    W'($urandom), ($urandom_range(0, 29) == 0));
    end
    for (int i = 0; (i < 60) &&
         !((exp_q.size() == 0) && (fifo_q.size() == 0) && !exp_inflight); i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    end
    checkOutput("final_drained", 32'(exp_q.size() + fifo_q.size()), 32'd0);
    tick();
    checkOutput("final_idle_valid", 32'(bus.m_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
